// File: rtl/cam_init_pkg.sv
// Shared state encoding, slave register map and table markers for camera_init_seq.
// Readback states are present only when CAM_INIT_READBACK_EN is defined.
package cam_init_pkg;

  localparam logic [11:0] REG_WDATA = 12'h000;
  localparam logic [11:0] REG_RDATA = 12'h004;
  localparam logic [11:0] REG_ADDR  = 12'h008;
  localparam logic [11:0] REG_CNTR  = 12'h00C;

  localparam logic [31:0] CNTR_WR_GO = 32'h1;
  localparam logic [31:0] CNTR_RD_GO = 32'h4;

  localparam logic [15:0] TBL_END   = 16'hFFFF;
  localparam logic [15:0] TBL_DELAY = 16'hFFFE;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_WR_ADDR,
    S_WR_DATA,
    S_WR_CTRL,
    S_POLL,
`ifdef CAM_INIT_READBACK_EN
    S_RB_CTRL,
    S_RB_POLL,
    S_RB_READ,
`endif
    S_DELAY,
    S_NEXT,
    S_DONE,
    S_ERROR
  } state_e;

  typedef enum logic [1:0] {
    PH_SETUP,
    PH_ACCESS,
    PH_SAMPLE
  } phase_e;

endpackage

// File: rtl/camera_init_rom.sv
// Registered init table for camera_init_seq, one {addr[15:0], data[7:0]} per index.
// Contents are shared by builds with and without CAM_INIT_READBACK_EN.
module camera_init_rom
  import cam_init_pkg::*;
#(
  parameter int TABLE_DEPTH = 256
) (
  input  logic                           CLK_SYS,
  input  logic                           RESET,
  input  logic [$clog2(TABLE_DEPTH)-1:0] idx,
  output logic [23:0]                    entry
);

  logic [23:0] entry_d;
  logic [23:0] entry_q;

  always_comb begin
    entry_d = {TBL_END, 8'h00};
    case (32'(idx))
      32'd0:   entry_d = {16'h3008, 8'h82};
      32'd1:   entry_d = {TBL_DELAY, 8'h02};
      32'd2:   entry_d = {16'h3103, 8'h11};
      32'd3:   entry_d = {TBL_DELAY, 8'h00};
      32'd4:   entry_d = {16'h3034, 8'h1A};
      32'd5:   entry_d = {TBL_END, 8'h00};
      default: ;
    endcase
  end

  always_ff @(posedge CLK_SYS or posedge RESET) begin
    if (RESET) entry_q <= '0;
    else       entry_q <= entry_d;
  end

  assign entry = entry_q;

endmodule

// File: rtl/camera_init_seq.sv
// APB master that walks the init table and programs the camera_ini slave.
// Define CAM_INIT_READBACK_EN to verify each write through the rdata register.
module camera_init_seq
  import cam_init_pkg::*;
#(
  parameter int TABLE_DEPTH = 256,
  parameter int DELAY_UNIT  = 50000,
  parameter int POLL_LIMIT  = 4095
) (
  input  logic                           CLK_SYS,
  input  logic                           RESET,
  input  logic                           start,
  output logic                           PCLKEN,
  output logic                           PSEL,
  output logic                           PENABLE,
  output logic                           PWRITE,
  output logic [11:0]                    PADDR,
  output logic [31:0]                    PWDATA,
  input  logic [31:0]                    PRDATA,
  output logic                           busy,
  output logic                           done,
  output logic                           error,
  output logic [$clog2(TABLE_DEPTH)-1:0] err_index
);

  localparam int IW = $clog2(TABLE_DEPTH);
  localparam int PW = $clog2(POLL_LIMIT + 1);
  localparam int DW = $clog2(255 * DELAY_UNIT + 1);

`ifdef CAM_INIT_READBACK_EN
  localparam state_e WR_OK = S_RB_CTRL;
`else
  localparam state_e WR_OK = S_NEXT;
`endif

  state_e        state_q, state_d;
  phase_e        ph_q, ph_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] err_idx_q, err_idx_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [DW-1:0] dly_q, dly_d;

  logic          xfer;
  logic          wr;
  state_e        after;
  logic [11:0]   addr;
  logic [31:0]   wdata;
  logic [23:0]   ent;
  logic [15:0]   ent_addr;
  logic [7:0]    ent_data;
  logic          unused_prdata;

  assign ent_addr      = ent[23:8];
  assign ent_data      = ent[7:0];
  assign unused_prdata = ^PRDATA;

  // Fed with the next index so the entry is valid in the FETCH cycle.
  camera_init_rom #(
    .TABLE_DEPTH(TABLE_DEPTH)
  ) u_rom (
    .CLK_SYS(CLK_SYS),
    .RESET  (RESET),
    .idx    (idx_d),
    .entry  (ent)
  );

  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    idx_d     = idx_q;
    err_idx_d = err_idx_q;
    poll_d    = poll_q;
    dly_d     = dly_q;
    xfer      = 1'b0;
    wr        = 1'b0;
    after     = state_q;
    addr      = 12'h000;
    wdata     = 32'h0;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d   = S_FETCH;
          idx_d     = '0;
          err_idx_d = '0;
        end
      end
      S_FETCH: begin
        if (ent_addr == TBL_END) begin
          state_d = S_DONE;
        end else if (ent_addr == TBL_DELAY) begin
          dly_d   = DW'(ent_data) * DW'(DELAY_UNIT);
          state_d = (ent_data == 8'h00) ? S_NEXT : S_DELAY;
        end else begin
          state_d = S_WR_ADDR;
        end
      end
      S_WR_ADDR: begin
        xfer  = 1'b1;
        wr    = 1'b1;
        addr  = REG_ADDR;
        wdata = {16'h0, ent_addr};
        after = S_WR_DATA;
      end
      S_WR_DATA: begin
        xfer  = 1'b1;
        wr    = 1'b1;
        addr  = REG_WDATA;
        wdata = {24'h0, ent_data};
        after = S_WR_CTRL;
      end
      S_WR_CTRL: begin
        xfer   = 1'b1;
        wr     = 1'b1;
        addr   = REG_CNTR;
        wdata  = CNTR_WR_GO;
        after  = S_POLL;
        poll_d = '0;
      end
      S_POLL: begin
        xfer = 1'b1;
        addr = REG_CNTR;
        if (ph_q == PH_SAMPLE) begin
          if (!PRDATA[0] && PRDATA[1]) begin
            state_d = WR_OK;
            poll_d  = '0;
          end else if (poll_q == PW'(POLL_LIMIT - 1)) begin
            state_d   = S_ERROR;
            err_idx_d = idx_q;
          end else begin
            poll_d = poll_q + 1'b1;
          end
        end
      end
`ifdef CAM_INIT_READBACK_EN
      S_RB_CTRL: begin
        xfer  = 1'b1;
        wr    = 1'b1;
        addr  = REG_CNTR;
        wdata = CNTR_RD_GO;
        after = S_RB_POLL;
      end
      S_RB_POLL: begin
        xfer = 1'b1;
        addr = REG_CNTR;
        if (ph_q == PH_SAMPLE) begin
          if (!PRDATA[2]) begin
            state_d = S_RB_READ;
            poll_d  = '0;
          end else if (poll_q == PW'(POLL_LIMIT - 1)) begin
            state_d   = S_ERROR;
            err_idx_d = idx_q;
          end else begin
            poll_d = poll_q + 1'b1;
          end
        end
      end
      S_RB_READ: begin
        xfer = 1'b1;
        addr = REG_RDATA;
        if (ph_q == PH_SAMPLE) begin
          if (PRDATA[7:0] == ent_data) begin
            state_d = S_NEXT;
          end else begin
            state_d   = S_ERROR;
            err_idx_d = idx_q;
          end
        end
      end
`endif
      S_DELAY: begin
        if (dly_q <= DW'(1)) begin
          dly_d   = '0;
          state_d = S_NEXT;
        end else begin
          dly_d = dly_q - 1'b1;
        end
      end
      S_NEXT: begin
        if (idx_q == IW'(TABLE_DEPTH - 1)) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Writes finish on access; reads get one more cycle to sample PRDATA.
    if (xfer) begin
      unique case (ph_q)
        PH_SETUP:  ph_d = PH_ACCESS;
        PH_ACCESS: ph_d = wr ? PH_SETUP : PH_SAMPLE;
        default:   ph_d = PH_SETUP;
      endcase
      if (wr && ph_q == PH_ACCESS) state_d = after;
    end
  end

  always_ff @(posedge CLK_SYS or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      ph_q      <= PH_SETUP;
      idx_q     <= '0;
      err_idx_q <= '0;
      poll_q    <= '0;
      dly_q     <= '0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      idx_q     <= idx_d;
      err_idx_q <= err_idx_d;
      poll_q    <= poll_d;
      dly_q     <= dly_d;
    end
  end

  assign PSEL      = xfer && (ph_q != PH_SAMPLE);
  assign PENABLE   = xfer && (ph_q == PH_ACCESS);
  assign PCLKEN    = PSEL;
  assign PWRITE    = PSEL && wr;
  assign PADDR     = PSEL ? addr : 12'h000;
  assign PWDATA    = (PSEL && wr) ? wdata : 32'h0;

  assign busy      = !(state_q inside {S_IDLE, S_DONE, S_ERROR});
  assign done      = (state_q == S_DONE);
  assign error     = (state_q == S_ERROR);
  assign err_index = err_idx_q;

endmodule

// File: tb/tb_camera_init_seq.sv
// Scoreboard bench for camera_init_seq against a mock camera_ini slave.
// Readback scenarios run only when CAM_INIT_READBACK_EN is defined.
module tb_camera_init_seq;
  import cam_init_pkg::*;

  localparam int TD = 16;
  localparam int DU = 10;
  localparam int PL = 8;
  localparam int IW = $clog2(TD);
  localparam int NT = 6;
  localparam logic [23:0] TBL [NT] = '{
    24'h300882, 24'hFFFE02, 24'h310311,
    24'hFFFE00, 24'h30341A, 24'hFFFF00
  };

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          pclken, psel, penable, pwrite;
  logic [11:0]   paddr;
  logic [31:0]   pwdata;
  logic [31:0]   prdata = 32'h0;
  logic          busy, done, error;
  logic [IW-1:0] err_index;

  always #5 clk = ~clk;

  camera_init_seq #(
    .TABLE_DEPTH(TD),
    .DELAY_UNIT (DU),
    .POLL_LIMIT (PL)
  ) dut (
    .CLK_SYS  (clk),
    .RESET    (rst),
    .start    (start),
    .PCLKEN   (pclken),
    .PSEL     (psel),
    .PENABLE  (penable),
    .PWRITE   (pwrite),
    .PADDR    (paddr),
    .PWDATA   (pwdata),
    .PRDATA   (prdata),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .err_index(err_index)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Mock slave knobs
  int unsigned busy_polls = 5;
  logic [15:0] hang_addr  = 16'h0000;
  logic        rb_bad     = 1'b0;

  logic [15:0] m_addr;
  logic [7:0]  m_wdata;
  int unsigned wr_left, rd_left;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_addr  <= '0;
      m_wdata <= '0;
      wr_left <= 0;
      rd_left <= 0;
      prdata  <= '0;
    end else if (psel && penable) begin
      if (pwrite) begin
        case (paddr)
          REG_ADDR:  m_addr  <= pwdata[15:0];
          REG_WDATA: m_wdata <= pwdata[7:0];
          REG_CNTR: begin
            if (pwdata[0])
              wr_left <= (m_addr == hang_addr) ? (1 << 30) : busy_polls;
            if (pwdata[2]) rd_left <= busy_polls;
          end
          default: ;
        endcase
      end else begin
        case (paddr)
          REG_CNTR: begin
            prdata <= {29'h0, rd_left != 0,
                       (wr_left == 0) && (rd_left == 0), wr_left != 0};
            if (wr_left != 0) wr_left <= wr_left - 1;
            if (rd_left != 0) rd_left <= rd_left - 1;
          end
          REG_RDATA:
            prdata <= {24'h0,
                       (rb_bad && m_wdata == 8'h82) ? 8'h80 : m_wdata};
          default: prdata <= '0;
        endcase
      end
    end
  end

  // Scoreboard and bus monitor
  logic [43:0] exp_q[$];
  int busy_cyc, rd_cnt, run, max_run, extra_wr, proto_err;
  logic prev_setup = 1'b0;

  always @(negedge clk) begin
    if (busy) busy_cyc++;
    if (busy && !pclken) begin
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
    if (pclken !== psel) proto_err++;
    if (psel && penable) begin
      if (!prev_setup) proto_err++;
      if (pwrite) begin
        if (exp_q.size() == 0) extra_wr++;
        else check("wr_txn", {paddr, pwdata}, exp_q.pop_front());
      end else begin
        rd_cnt++;
      end
    end
    prev_setup = psel && !penable;
  end

  task automatic model(output int bc, output int rc,
                       output bit ok, output int ei);
    logic [15:0] a;
    logic [7:0]  d;
    bc = 0; rc = 0; ok = 1'b1; ei = 0;
    for (int i = 0; i < NT; i++) begin
      a = TBL[i][23:8];
      d = TBL[i][7:0];
      if (a == TBL_END) begin
        bc += 1;
        return;
      end
      if (a == TBL_DELAY) begin
        bc += 2 + int'(d) * DU;
        continue;
      end
      exp_q.push_back({REG_ADDR, 16'h0, a});
      exp_q.push_back({REG_WDATA, 24'h0, d});
      exp_q.push_back({REG_CNTR, CNTR_WR_GO});
      bc += 7;
      if (a == hang_addr) begin
        bc += 3 * PL;
        rc += PL;
        ok = 1'b0;
        ei = i;
        return;
      end
      bc += 3 * (busy_polls + 1);
      rc += busy_polls + 1;
`ifdef CAM_INIT_READBACK_EN
      exp_q.push_back({REG_CNTR, CNTR_RD_GO});
      bc += 2 + 3 * (busy_polls + 1) + 3;
      rc += busy_polls + 2;
      if (rb_bad && d == 8'h82) begin
        ok = 1'b0;
        ei = i;
        return;
      end
`endif
      bc += 1;
    end
  endtask

  task automatic run_and_check(string tag, int mid_start);
    int bc, rc, ei, cyc;
    bit ok;
    exp_q.delete();
    model(bc, rc, ok, ei);
    busy_cyc = 0; rd_cnt = 0; max_run = 0;
    extra_wr = 0; run = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(done || error) && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      start = (mid_start > 0 && cyc == mid_start);
    end
    start = 1'b0;
    check({tag, ".in_time"}, cyc < 4000, 1);
    check({tag, ".done"}, done, ok);
    check({tag, ".error"}, error, !ok);
    check({tag, ".busy"}, busy, 0);
    if (!ok) check({tag, ".err_index"}, err_index, ei);
    check({tag, ".busy_cycles"}, busy_cyc, bc);
    check({tag, ".reads"}, rd_cnt, rc);
    check({tag, ".missing_wr"}, exp_q.size(), 0);
    check({tag, ".extra_wr"}, extra_wr, 0);
    check({tag, ".protocol"}, proto_err, 0);
  endtask

  int cyc;

  initial begin
    repeat (3) @(negedge clk);
    check("rst.psel", psel, 0);
    check("rst.penable", penable, 0);
    check("rst.pclken", pclken, 0);
    check("rst.pwrite", pwrite, 0);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.error", error, 0);
    check("rst.err_index", err_index, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_and_check("full", 0);
    check("full.max_idle_run", max_run, 25);
    run_and_check("replay", 0);
    run_and_check("busy_start", 40);

    hang_addr = 16'h3008;
    run_and_check("timeout_idx0", 0);
    hang_addr = 16'h3103;
    run_and_check("timeout_idx2", 0);
    hang_addr = 16'h0000;
    run_and_check("from_error", 0);

    exp_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(psel && penable && pwrite && paddr == REG_WDATA)
           && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("arst.reached_wdata", cyc < 100, 1);
    #1 rst = 1'b1;
    #1;
    check("arst.psel", psel, 0);
    check("arst.penable", penable, 0);
    check("arst.pclken", pclken, 0);
    check("arst.busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("arst.no_restart_busy", busy, 0);
    check("arst.no_restart_psel", psel, 0);
    check("arst.done", done, 0);
    run_and_check("after_rst", 0);

`ifdef CAM_INIT_READBACK_EN
    rb_bad = 1'b1;
    run_and_check("rb_mismatch", 0);
    rb_bad = 1'b0;
    run_and_check("rb_match", 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
